lcd_bus_responder: RTL and testbench

- HD44780-compatible responder model for the parallel LCD write bus (EN/RS/RW/8-bit data) driven by the board's LCD driver.
- Decodes every latched byte into command or character actions on an internal 80-byte DDRAM shadow, address counter and display-control state.
- Enforces controller busy timing.
- Used in simulation and on-FPGA self-check; exposes DDRAM readback and protocol-violation flags.

---
 rtl/lcd_bus_if.sv | 10 +
 rtl/lcd_bus_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_if.sv
// Parallel HD44780 write bus (EN/RS/RW/data) between an LCD driver and the bus responder.
interface lcd_bus_if;
  logic       EN_in;
  logic       RS_in;
  logic       RW_in;
  logic [7:0] data_in;

  modport master (output EN_in, RS_in, RW_in, data_in);
  modport slave  (input  EN_in, RS_in, RW_in, data_in);
endinterface

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible write-bus responder: DDRAM shadow, address counter, display state,
// busy timing and sticky protocol-violation flags.
module lcd_bus_responder #(
  parameter int unsigned BUSY_CYCLES       = 2000,
  parameter int unsigned CLEAR_BUSY_CYCLES = 82000,
  parameter int unsigned MIN_EN_HIGH       = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  lcd_bus_if.slave    bus,
  input  logic [6:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [6:0]  ac,
  output logic        disp_on,
  output logic        cursor_on,
  output logic        blink_on,
  output logic        inc_mode,
  output logic        shift_mode,
  output logic        two_line,
  output logic [5:0]  disp_shift,
  output logic        cmd_strobe,
  output logic        data_strobe,
  output logic [7:0]  last_byte,
  output logic        busy,
  output logic        busy_violation,
  output logic        rw_error,
  output logic        short_pulse
);

  localparam int unsigned MAX_BUSY = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES
                                                                      : BUSY_CYCLES;
  localparam int CW = $clog2(MAX_BUSY + 1);
  localparam int HW = $clog2(MIN_EN_HIGH + 1);
  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_BUSY_CYCLES - 1);
  localparam logic [HW-1:0] HIGH_MIN   = HW'(MIN_EN_HIGH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BUSY} state_t;

  // Address-counter stepping and folding under the current line mode.
  function automatic logic [6:0] ac_inc(input logic [6:0] a, input logic tl);
    if (tl) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    return (a == 7'h4F) ? 7'h00 : a + 7'd1;
  endfunction

  function automatic logic [6:0] ac_dec(input logic [6:0] a, input logic tl);
    if (tl) return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    return (a == 7'h00) ? 7'h4F : a - 7'd1;
  endfunction

  function automatic logic [6:0] ac_fold(input logic [6:0] a, input logic tl);
    if (tl) begin
      if (a >= 7'h28 && a < 7'h40) return 7'h40;
      if (a >= 7'h68)              return 7'h00;
      return a;
    end
    return (a >= 7'h50) ? 7'h00 : a;
  endfunction

  // {valid, line*40 + column} for a DDRAM address.
  function automatic logic [7:0] map_idx(input logic [6:0] a, input logic tl);
    if (tl) begin
      if (a < 7'h28)               return {1'b1, a};
      if (a >= 7'h40 && a < 7'h68) return {1'b1, a - 7'd24};
      return 8'h00;
    end
    return (a < 7'h50) ? {1'b1, a} : 8'h00;
  endfunction

  function automatic logic [5:0] ds_inc(input logic [5:0] d);
    return (d == 6'd39) ? 6'd0 : d + 6'd1;
  endfunction

  function automatic logic [5:0] ds_dec(input logic [5:0] d);
    return (d == 6'd0) ? 6'd39 : d - 6'd1;
  endfunction

  state_t          r_state;
  logic [10:0]     r_sync1, r_sync2;
  logic            r_en_prev;
  logic [HW-1:0]   r_high;
  logic [CW-1:0]   r_busy_cnt;
  logic            r_long;
  logic [7:0]      r_ddram [80];
  logic [6:0]      r_ac;
  logic            r_disp_on, r_cursor_on, r_blink_on;
  logic            r_inc_mode, r_shift_mode, r_two_line;
  logic [5:0]      r_disp_shift;
  logic            r_cmd_strobe, r_data_strobe;
  logic [7:0]      r_last_byte;
  logic            r_busy, r_busy_violation, r_rw_error, r_short_pulse;
  logic [7:0]      r_rd_data;

  logic            w_en, w_rs, w_rw, w_fall, w_short, w_accept;
  logic [7:0]      w_data, w_wr_map, w_rd_map;

  assign w_en     = r_sync2[10];
  assign w_rs     = r_sync2[9];
  assign w_rw     = r_sync2[8];
  assign w_data   = r_sync2[7:0];
  assign w_fall   = r_en_prev & ~w_en;
  assign w_short  = (r_high < HIGH_MIN);
  assign w_accept = w_fall & ~w_short & ~w_rw;
  assign w_wr_map = map_idx(r_ac, r_two_line);
  assign w_rd_map = map_idx(rd_addr, r_two_line);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_sync1          <= '0;
      r_sync2          <= '0;
      r_en_prev        <= 1'b0;
      r_high           <= '0;
      r_busy_cnt       <= '0;
      r_long           <= 1'b0;
      // NOTE: the DDRAM shadow is a resettable register array because its 0x20 reset contents are observable.
      for (int i = 0; i < 80; i++) r_ddram[i] <= 8'h20;
      r_ac             <= '0;
      r_disp_on        <= 1'b0;
      r_cursor_on      <= 1'b0;
      r_blink_on       <= 1'b0;
      r_inc_mode       <= 1'b1;
      r_shift_mode     <= 1'b0;
      r_two_line       <= 1'b0;
      r_disp_shift     <= '0;
      r_cmd_strobe     <= 1'b0;
      r_data_strobe    <= 1'b0;
      r_last_byte      <= '0;
      r_busy           <= 1'b0;
      r_busy_violation <= 1'b0;
      r_rw_error       <= 1'b0;
      r_short_pulse    <= 1'b0;
    end else begin
      r_sync1       <= {bus.EN_in, bus.RS_in, bus.RW_in, bus.data_in};
      r_sync2       <= r_sync1;
      r_en_prev     <= w_en;
      r_high        <= w_en ? ((r_high == HIGH_MIN) ? r_high : r_high + HW'(1)) : '0;
      r_cmd_strobe  <= 1'b0;
      r_data_strobe <= 1'b0;

      if (w_fall && w_short)          r_short_pulse <= 1'b1;
      if (w_fall && !w_short && w_rw) r_rw_error    <= 1'b1;

      case (r_state)
        S_EXEC: begin
          r_busy     <= 1'b1;
          r_busy_cnt <= r_long ? CLEAR_LOAD : BUSY_LOAD;
          r_state    <= S_BUSY;
        end
        S_BUSY: begin
          if (r_busy_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_busy_cnt <= r_busy_cnt - CW'(1);
          end
        end
        default: ;
      endcase

      // An accepted byte executes immediately; the EXEC cycle then (re)starts the busy timer.
      if (w_accept) begin
        if (r_busy || r_state == S_EXEC) r_busy_violation <= 1'b1;
        r_state     <= S_EXEC;
        r_last_byte <= w_data;
        r_long      <= !w_rs && (w_data == 8'h01 || w_data == 8'h02 || w_data == 8'h03);
        if (w_rs) begin
          r_data_strobe <= 1'b1;
          if (w_wr_map[7]) r_ddram[w_wr_map[6:0]] <= w_data;
          r_ac <= r_inc_mode ? ac_inc(r_ac, r_two_line) : ac_dec(r_ac, r_two_line);
          if (r_shift_mode) r_disp_shift <= r_inc_mode ? ds_inc(r_disp_shift) : ds_dec(r_disp_shift);
        end else begin
          r_cmd_strobe <= 1'b1;
          casez (w_data)
            8'b1???????: r_ac <= ac_fold(w_data[6:0], r_two_line);
            8'b01??????: ;
            8'b001?????: r_two_line <= w_data[3];
            8'b0001????: begin
              if (w_data[3]) r_disp_shift <= w_data[2] ? ds_dec(r_disp_shift) : ds_inc(r_disp_shift);
              else           r_ac <= w_data[2] ? ac_inc(r_ac, r_two_line) : ac_dec(r_ac, r_two_line);
            end
            8'b00001???: begin
              r_disp_on   <= w_data[2];
              r_cursor_on <= w_data[1];
              r_blink_on  <= w_data[0];
            end
            8'b000001??: begin
              r_inc_mode   <= w_data[1];
              r_shift_mode <= w_data[0];
            end
            8'b0000001?: begin
              r_ac         <= '0;
              r_disp_shift <= '0;
            end
            8'b00000001: begin
              for (int i = 0; i < 80; i++) r_ddram[i] <= 8'h20;
              r_ac         <= '0;
              r_disp_shift <= '0;
              r_inc_mode   <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= 8'h20;
    else        r_rd_data <= w_rd_map[7] ? r_ddram[w_rd_map[6:0]] : 8'h20;
  end

  assign rd_data        = r_rd_data;
  assign ac             = r_ac;
  assign disp_on        = r_disp_on;
  assign cursor_on      = r_cursor_on;
  assign blink_on       = r_blink_on;
  assign inc_mode       = r_inc_mode;
  assign shift_mode     = r_shift_mode;
  assign two_line       = r_two_line;
  assign disp_shift     = r_disp_shift;
  assign cmd_strobe     = r_cmd_strobe;
  assign data_strobe    = r_data_strobe;
  assign last_byte      = r_last_byte;
  assign busy           = r_busy;
  assign busy_violation = r_busy_violation;
  assign rw_error       = r_rw_error;
  assign short_pulse    = r_short_pulse;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: directed protocol scenarios plus randomized bytes against a
// position-based behavioural model of the controller.
module tb_lcd_bus_responder;

  localparam int BC  = 20;
  localparam int CBC = 60;
  localparam int MEH = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_data, last_byte;
  logic [6:0] ac;
  logic [5:0] disp_shift;
  logic       disp_on, cursor_on, blink_on, inc_mode, shift_mode, two_line;
  logic       cmd_strobe, data_strobe, busy, busy_violation, rw_error, short_pulse;

  int n_pass = 0, n_total = 0;
  int n_ds = 0, n_cs = 0;
  int g_len;

  always #5 clk = ~clk;

  lcd_bus_if bus ();

  lcd_bus_responder #(
    .BUSY_CYCLES(BC), .CLEAR_BUSY_CYCLES(CBC), .MIN_EN_HIGH(MEH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rd_addr(rd_addr), .rd_data(rd_data), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .inc_mode(inc_mode),
    .shift_mode(shift_mode), .two_line(two_line), .disp_shift(disp_shift),
    .cmd_strobe(cmd_strobe), .data_strobe(data_strobe), .last_byte(last_byte), .busy(busy),
    .busy_violation(busy_violation), .rw_error(rw_error), .short_pulse(short_pulse)
  );

  always @(negedge clk) if (rst_n) begin
    if (data_strobe) n_ds++;
    if (cmd_strobe)  n_cs++;
  end

  // Model: address counter kept as linear position (line*40 + column).
  logic [7:0] m_ram [80];
  int m_pos, m_ds;
  bit m_tl, m_inc, m_shm, m_on, m_cur, m_blk;
  logic [7:0] m_last;

  function automatic int pos2addr(int p, bit tl);
    return (tl && p >= 40) ? 64 + p - 40 : p;
  endfunction

  function automatic int addr2pos(int a, bit tl);
    if (tl) begin
      if (a < 40)  return a;
      if (a < 64)  return 40;
      if (a < 104) return a - 24;
      return 0;
    end
    return (a < 80) ? a : 0;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
    m_pos = 0; m_ds = 0; m_tl = 0; m_inc = 1; m_shm = 0;
    m_on = 0; m_cur = 0; m_blk = 0; m_last = 8'h00;
  endfunction

  function automatic void m_apply(bit rs, logic [7:0] d);
    m_last = d;
    if (rs) begin
      m_ram[m_pos] = d;
      m_pos = m_inc ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
      if (m_shm) m_ds = m_inc ? (m_ds + 1) % 40 : (m_ds + 39) % 40;
    end else if (d[7]) m_pos = addr2pos(int'(d[6:0]), m_tl);
    else if (d[6]) begin end
    else if (d[5]) m_tl = d[3];
    else if (d[4]) begin
      if (d[3]) m_ds = d[2] ? (m_ds + 39) % 40 : (m_ds + 1) % 40;
      else      m_pos = d[2] ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
    end else if (d[3]) begin m_on = d[2]; m_cur = d[1]; m_blk = d[0]; end
    else if (d[2]) begin m_inc = d[1]; m_shm = d[0]; end
    else if (d[1]) begin m_pos = 0; m_ds = 0; end
    else if (d[0]) begin
      for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
      m_pos = 0; m_ds = 0; m_inc = 1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse(input logic rs, input logic [7:0] d, input logic rw, input int high);
    @(negedge clk);
    bus.RS_in = rs; bus.RW_in = rw; bus.data_in = d; bus.EN_in = 1'b1;
    repeat (high) @(negedge clk);
    bus.EN_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_busy();
    int n = 0;
    g_len = 0;
    while (busy !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    while (busy === 1'b1 && g_len < CBC + 40) begin g_len++; @(negedge clk); end
    if (g_len >= CBC + 40) check("busy_timeout", 32'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    pulse(rs, d, 1'b0, 16);
    wait_busy();
  endtask

  task automatic read_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
    rd_addr = a;
    @(negedge clk);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_op(input logic rs, input logic [7:0] d);
    m_apply(rs, d);
    send(rs, d);
    check("rnd_ac", 32'(ac), 32'(pos2addr(m_pos, m_tl)));
    check("rnd_shift", 32'(disp_shift), 32'(m_ds));
    check("rnd_ctl", 32'({disp_on, cursor_on, blink_on, inc_mode, shift_mode, two_line}),
          32'({m_on, m_cur, m_blk, m_inc, m_shm, m_tl}));
    check("rnd_last", 32'(last_byte), 32'(m_last));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int sel, ds0, cs0;
    bus.EN_in = 1'b0; bus.RS_in = 1'b0; bus.RW_in = 1'b0; bus.data_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ac", 32'(ac), 0);
    check("rst_rd", 32'(rd_data), 32'h20);
    check("rst_ctl", 32'({disp_on, cursor_on, blink_on, inc_mode, shift_mode, two_line}), 32'b000100);
    check("rst_shift", 32'(disp_shift), 0);
    check("rst_flags", 32'({busy, busy_violation, rw_error, short_pulse, cmd_strobe, data_strobe}), 0);
    check("rst_last", 32'(last_byte), 0);

    // Init sequence and "LOAD"; busy windows measured
    send(1'b0, 8'h38); check("busy_len", 32'(g_len), 32'(BC));
    send(1'b0, 8'h01); check("clear_busy_len", 32'(g_len), 32'(CBC));
    send(1'b0, 8'h06);
    send(1'b0, 8'h0C);
    send(1'b1, 8'h4C); send(1'b1, 8'h4F); send(1'b1, 8'h41); send(1'b1, 8'h44);
    read_chk("load0", 7'h00, 8'h4C);
    read_chk("load1", 7'h01, 8'h4F);
    read_chk("load2", 7'h02, 8'h41);
    read_chk("load3", 7'h03, 8'h44);
    check("load_ac", 32'(ac), 32'h04);
    check("load_ctl", 32'({two_line, disp_on, cursor_on}), 32'b110);
    check("data_strobes", 32'(n_ds), 4);
    check("cmd_strobes", 32'(n_cs), 4);
    check("last_byte", 32'(last_byte), 32'h44);

    // Second line
    send(1'b0, 8'hC0); send(1'b1, 8'h2B); send(1'b1, 8'h30);
    read_chk("line2_40", 7'h40, 8'h2B);
    read_chk("line2_41", 7'h41, 8'h30);
    check("line2_ac", 32'(ac), 32'h42);

    // Wraps and set-address folding
    send(1'b0, 8'hA7); send(1'b1, 8'h41); check("wrap_27", 32'(ac), 32'h40);
    send(1'b0, 8'hE7); send(1'b1, 8'h42); check("wrap_67", 32'(ac), 32'h00);
    send(1'b0, 8'h10); check("dec_00", 32'(ac), 32'h67);
    read_chk("wrap_rd27", 7'h27, 8'h41);
    read_chk("wrap_rd67", 7'h67, 8'h42);
    read_chk("rd_invalid", 7'h30, 8'h20);
    send(1'b0, 8'hB0); check("fold_30", 32'(ac), 32'h40);
    send(1'b0, 8'hF0); check("fold_70", 32'(ac), 32'h00);

    // Cursor / display shifts
    send(1'b0, 8'h80);
    for (int i = 0; i < 10; i++) send(1'b0, 8'h14);
    check("cur_right10", 32'(ac), 32'h0A);
    read_chk("shift_ram0", 7'h00, 8'h4C);
    read_chk("shift_ram3", 7'h03, 8'h44);
    send(1'b0, 8'h1C); check("dshift_1c", 32'(disp_shift), 39);
    send(1'b0, 8'h18); send(1'b0, 8'h18); check("dshift_18x2", 32'(disp_shift), 1);

    // Byte during clear busy window
    pulse(1'b0, 8'h01, 1'b0, 16);
    repeat (6) @(negedge clk);
    check("viol_pre_busy", 32'(busy), 1);
    pulse(1'b1, 8'h58, 1'b0, 16);
    wait_busy();
    check("busy_violation", 32'(busy_violation), 1);
    read_chk("viol_exec", 7'h00, 8'h58);
    read_chk("viol_clear", 7'h01, 8'h20);
    check("viol_ac", 32'(ac), 32'h01);

    // EN width boundary, short pulse and RW
    pulse(1'b1, 8'h33, 1'b0, 5); wait_busy();
    check("short_flag", 32'(short_pulse), 1);
    check("short_ac", 32'(ac), 32'h01);
    pulse(1'b1, 8'h34, 1'b0, MEH - 1); wait_busy();
    check("short_11_ac", 32'(ac), 32'h01);
    pulse(1'b1, 8'h31, 1'b0, MEH); wait_busy();
    check("min_high_ac", 32'(ac), 32'h02);
    check("min_high_last", 32'(last_byte), 32'h31);
    pulse(1'b1, 8'h35, 1'b1, 16); wait_busy();
    check("rw_flag", 32'(rw_error), 1);
    check("rw_ac", 32'(ac), 32'h02);
    check("rw_last", 32'(last_byte), 32'h31);

    // Asynchronous reset mid data-busy, mid clear-busy and mid pulse
    pulse(1'b1, 8'h5A, 1'b0, 16);
    #2 rst_n = 1'b0;
    #1 check("rst_data_busy", 32'({busy, ac}), 0);
    check("rst_data_flags", 32'({busy_violation, rw_error, short_pulse}), 0);
    @(negedge clk); rst_n = 1'b1;
    read_chk("rst_ram00", 7'h00, 8'h20);
    read_chk("rst_ram02", 7'h02, 8'h20);
    read_chk("rst_ram27", 7'h27, 8'h20);
    send(1'b0, 8'h38); send(1'b1, 8'h55);
    pulse(1'b0, 8'h01, 1'b0, 16);
    repeat (10) @(negedge clk);
    check("clr_pre_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check("rst_clr_busy", 32'(busy), 0);
    check("rst_clr_ac", 32'(ac), 0);
    check("rst_clr_tl", 32'(two_line), 0);
    check("rst_clr_rd", 32'(rd_data), 32'h20);
    @(negedge clk); rst_n = 1'b1;
    ds0 = n_ds; cs0 = n_cs;
    @(negedge clk);
    bus.RS_in = 1'b1; bus.data_in = 8'h66; bus.EN_in = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk); bus.EN_in = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_pulse_strobes", 32'(n_ds - ds0 + n_cs - cs0), 0);
    check("rst_pulse_state", 32'({ac, short_pulse, last_byte}), 0);

    // Randomized bytes against the model
    m_reset();
    do_op(1'b0, 8'h38);
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 15);
      d = 8'($urandom);
      if (sel < 7) do_op(1'b1, d);
      else case (sel)
        7:  do_op(1'b0, {1'b1, d[6:0]});
        8:  do_op(1'b0, {6'b000001, d[1:0]});
        9:  do_op(1'b0, {5'b00001, d[2:0]});
        10, 11: do_op(1'b0, {4'b0001, d[3:0]});
        12: do_op(1'b0, {2'b01, d[5:0]});
        13: do_op(1'b0, {7'b0000001, d[0]});
        14: do_op(1'b0, {3'b001, d[4], 1'b1, d[2:0]});
        default: do_op(1'b0, (d[2:0] == 3'd0) ? 8'h01 : {1'b1, d[6:0]});
      endcase
    end
    for (int p = 0; p < 80; p++) read_chk("rnd_ram", 7'(pos2addr(p, 1'b1)), m_ram[p]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
